// File: rtl/sad_search_ctrl.sv
// Motion-search controller: issues candidate indices into a SAD pipeline, tracks the
// returning results and keeps the minimum SAD and its index.
module sad_search_ctrl #(
  parameter int unsigned IDX_W = 16,
  parameter int unsigned SAD_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [IDX_W-1:0] num_cand_i,
  input  logic             abort_i,
  input  logic             pipe_hold_i,
  output logic             issue_valid_o,
  output logic [IDX_W-1:0] issue_index_o,
  output logic             issue_trigger_o,
  input  logic             res_valid_i,
  input  logic [IDX_W-1:0] res_index_i,
  input  logic [SAD_W-1:0] res_sad_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [IDX_W-1:0] best_index_o,
  output logic [SAD_W-1:0] best_sad_o,
  output logic             err_o
);

  // One extra bit so a count of 2^IDX_W-1 never wraps.
  localparam int unsigned CntW = IDX_W + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CntW-1:0]  res_cnt_q, res_cnt_d;
  logic [CntW-1:0]  res_cnt_inc;
  logic             issue_valid_q, issue_valid_d;
  logic             issue_trigger_q, issue_trigger_d;
  logic [IDX_W-1:0] issue_index_q, issue_index_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] best_index_q, best_index_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic             err_q, err_d;
  logic             res_take;

  assign res_cnt_inc = res_cnt_q + CntW'(1);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    issue_cnt_d     = issue_cnt_q;
    res_cnt_d       = res_cnt_q;
    issue_valid_d   = 1'b0;
    issue_trigger_d = 1'b0;
    issue_index_d   = issue_index_q;
    done_d          = 1'b0;
    best_index_d    = best_index_q;
    best_sad_d      = best_sad_q;
    err_d           = err_q;
    res_take        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cnt_d        = {1'b0, num_cand_i};
          issue_cnt_d  = '0;
          res_cnt_d    = '0;
          best_sad_d   = '1;
          best_index_d = '0;
          err_d        = 1'b0;
          if (num_cand_i == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StIssue;
            // Registered issue: candidate 0 is visible in the first ISSUE cycle.
            if (!pipe_hold_i) begin
              issue_valid_d   = 1'b1;
              issue_index_d   = '0;
              issue_trigger_d = (num_cand_i == IDX_W'(1));
              issue_cnt_d     = CntW'(1);
            end
          end
        end
      end
      StIssue, StDrain: begin
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          res_take = res_valid_i;
          if (res_valid_i && (res_cnt_inc == cnt_q)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else if (state_q == StIssue) begin
            if (issue_trigger_q) begin
              state_d = StDrain;
            end else if (!pipe_hold_i && (issue_cnt_q < cnt_q)) begin
              issue_valid_d   = 1'b1;
              issue_index_d   = issue_cnt_q[IDX_W-1:0];
              issue_trigger_d = (issue_cnt_q == (cnt_q - CntW'(1)));
              issue_cnt_d     = issue_cnt_q + CntW'(1);
            end
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (res_take) begin
      res_cnt_d = res_cnt_inc;
      if ({1'b0, res_index_i} != res_cnt_q) err_d = 1'b1;
      // Strict compare keeps the earlier index on ties.
      if (res_sad_i < best_sad_q) begin
        best_sad_d   = res_sad_i;
        best_index_d = res_index_i;
      end
    end
    if (res_valid_i && ((state_q == StIdle) || (state_q == StDone))) err_d = 1'b1;

    busy_d = (state_d == StIssue) || (state_d == StDrain);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      issue_cnt_q     <= '0;
      res_cnt_q       <= '0;
      issue_valid_q   <= 1'b0;
      issue_trigger_q <= 1'b0;
      issue_index_q   <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      best_index_q    <= '0;
      best_sad_q      <= '1;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      issue_cnt_q     <= issue_cnt_d;
      res_cnt_q       <= res_cnt_d;
      issue_valid_q   <= issue_valid_d;
      issue_trigger_q <= issue_trigger_d;
      issue_index_q   <= issue_index_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      best_index_q    <= best_index_d;
      best_sad_q      <= best_sad_d;
      err_q           <= err_d;
    end
  end

  assign issue_valid_o   = issue_valid_q;
  assign issue_index_o   = issue_index_q;
  assign issue_trigger_o = issue_trigger_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign best_index_o    = best_index_q;
  assign best_sad_o      = best_sad_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl: table of directed searches, hand-written abort/reset
// sequences and randomized searches against a transaction-level reference model.
module tb_sad_search_ctrl;

  localparam int unsigned IdxW = 16;
  localparam int unsigned SadW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            pipe_hold = 1'b0;
  logic            res_valid = 1'b0;
  logic [IdxW-1:0] num_cand = '0;
  logic [IdxW-1:0] res_index = '0;
  logic [SadW-1:0] res_sad = '0;
  logic            issue_valid, issue_trigger, busy, done, err;
  logic [IdxW-1:0] issue_index, best_index;
  logic [SadW-1:0] best_sad;

  always #5 clk = ~clk;

  sad_search_ctrl #(.IDX_W(IdxW), .SAD_W(SadW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .num_cand_i     (num_cand),
    .abort_i        (abort),
    .pipe_hold_i    (pipe_hold),
    .issue_valid_o  (issue_valid),
    .issue_index_o  (issue_index),
    .issue_trigger_o(issue_trigger),
    .res_valid_i    (res_valid),
    .res_index_i    (res_index),
    .res_sad_i      (res_sad),
    .busy_o         (busy),
    .done_o         (done),
    .best_index_o   (best_index),
    .best_sad_o     (best_sad),
    .err_o          (err)
  );

  typedef struct {
    int              n;
    int              lat;
    int              hold;
    int              corrupt;
    int              exp_done;
    logic [IdxW-1:0] exp_idx;
    logic [SadW-1:0] exp_sad;
    logic            exp_err;
    logic [95:0]     sads;
  } scn_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: search as a set of counts, not as a state machine.
  bit              m_search, m_done, m_iv, m_trig, m_err;
  int              m_n, m_issued, m_got;
  logic [IdxW-1:0] m_idx, m_best_idx;
  logic [SadW-1:0] m_best_sad;

  logic [SadW-1:0] sad_tab [64];
  int              pq_idx[$];
  int              pq_due[$];
  int              lat = 0, corrupt_at = -1, res_ord = 0;
  int              done_cnt = 0, done_cyc = -1, next_issue = 0, cur_n = 0;
  logic [IdxW-1:0] d_idx;
  logic [SadW-1:0] d_sad;
  logic            d_err;
  scn_t            tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic scn_t mk(int n, int l, int h, int c, int ed, int ei, int es, bit ee,
                              logic [95:0] s);
    scn_t r;
    r.n = n; r.lat = l; r.hold = h; r.corrupt = c; r.exp_done = ed;
    r.exp_idx = IdxW'(ei); r.exp_sad = SadW'(es); r.exp_err = ee; r.sads = s;
    return r;
  endfunction

  task automatic model_reset();
    m_search = 0; m_done = 0; m_iv = 0; m_trig = 0; m_err = 0;
    m_n = 0; m_issued = 0; m_got = 0; m_idx = '0; m_best_idx = '0; m_best_sad = '1;
  endtask

  task automatic model_issue();
    m_iv = 1; m_idx = IdxW'(m_issued); m_trig = (m_issued == m_n - 1); m_issued++;
  endtask

  task automatic model_edge();
    bit trig_prev;
    trig_prev = m_trig;
    m_iv = 0; m_trig = 0;
    if (m_done) begin
      m_done = 0;
      if (res_valid) m_err = 1;
    end else if (!m_search) begin
      if (start) begin
        m_best_sad = '1; m_best_idx = '0; m_err = 0;
        m_n = int'(num_cand); m_issued = 0; m_got = 0;
        if (m_n == 0) m_done = 1;
        else begin
          m_search = 1;
          if (!pipe_hold) model_issue();
        end
      end
      if (res_valid) m_err = 1;
    end else if (abort) begin
      m_search = 0;
    end else begin
      if (res_valid) begin
        if (int'(res_index) != m_got) m_err = 1;
        if (res_sad < m_best_sad) begin m_best_sad = res_sad; m_best_idx = res_index; end
        m_got++;
      end
      if (m_got == m_n) begin m_search = 0; m_done = 1; end
      else if (!trig_prev && !pipe_hold && m_issued < m_n) model_issue();
    end
  endtask

  task automatic model_compare();
    chk("busy", 32'(busy), 32'(m_search));
    chk("done", 32'(done), 32'(m_done));
    chk("issue_valid", 32'(issue_valid), 32'(m_iv));
    chk("issue_trigger", 32'(issue_trigger), 32'(m_trig));
    chk("err", 32'(err), 32'(m_err));
    chk("best_index", 32'(best_index), 32'(m_best_idx));
    chk("best_sad", 32'(best_sad), 32'(m_best_sad));
    if (m_iv) chk("issue_index", 32'(issue_index), 32'(m_idx));
  endtask

  // One clock: present due results, clock, update model, compare, feed the pipeline.
  task automatic step();
    res_valid = 1'b0;
    if (pq_due.size() > 0 && pq_due[0] <= cyc) begin
      res_valid = 1'b1;
      res_index = IdxW'(pq_idx[0]);
      res_sad   = sad_tab[pq_idx[0] % 64];
      if (res_ord == corrupt_at) res_index = IdxW'(5);
      res_ord++;
      void'(pq_idx.pop_front());
      void'(pq_due.pop_front());
    end
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    model_compare();
    if (issue_valid === 1'b1) begin
      chk("issue_seq", 32'(issue_index), 32'(next_issue));
      if (issue_trigger === 1'b1) chk("trig_idx", 32'(issue_index), 32'(cur_n - 1));
      next_issue++;
      pq_idx.push_back(int'(issue_index));
      pq_due.push_back(cyc + lat);
    end
    if (done === 1'b1) begin
      done_cnt++; done_cyc = cyc; d_idx = best_index; d_sad = best_sad; d_err = err;
    end
    res_valid = 1'b0;
  endtask

  task automatic begin_search(input int n, input int l, input int c);
    pq_idx.delete(); pq_due.delete();
    lat = l; corrupt_at = c; res_ord = 0; done_cnt = 0; done_cyc = -1;
    next_issue = 0; cur_n = n; cyc = 0;
    num_cand = IdxW'(n); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_scn(input scn_t s, input bit rnd);
    int guard;
    guard = 0;
    begin_search(s.n, s.lat, s.corrupt);
    while (done_cnt == 0 && guard < 400) begin
      pipe_hold = rnd ? ($urandom_range(0, 3) == 0) : (cyc >= 1 && cyc < 1 + s.hold);
      start = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      step();
      guard++;
    end
    pipe_hold = 1'b0; start = 1'b0;
    chk("done_seen", 32'(done_cnt > 0), 32'd1);
    step(); step();
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("issue_count", 32'(next_issue), 32'(s.n));
  endtask

  task automatic check_table_entry(input scn_t s);
    chk("done_cycle", 32'(done_cyc), 32'(s.exp_done));
    chk("tbl_best_idx", 32'(d_idx), 32'(s.exp_idx));
    chk("tbl_best_sad", 32'(d_sad), 32'(s.exp_sad));
    chk("tbl_err", 32'(d_err), 32'(s.exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    scn_t            s;
    logic [SadW-1:0] ref_sad;
    int              ref_idx;

    tbl[0] = mk(4, 4, 0, -1, 9, 1, 20, 0, {16'd0, 16'd0, 16'd70, 16'd20, 16'd20, 16'd50});
    tbl[1] = mk(3, 2, 2, -1, 8, 2, 7, 0, {16'd0, 16'd0, 16'd0, 16'd7, 16'd8, 16'd9});
    tbl[2] = mk(0, 0, 0, -1, 1, 0, 'hFFFF, 0, 96'd0);
    tbl[3] = mk(1, 0, 0, -1, 2, 0, 5, 0, {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd5});
    tbl[4] = mk(5, 1, 0, -1, 7, 0, 'hFFFF, 0, {16'd0, {5{16'hFFFF}}});
    tbl[5] = mk(4, 1, 0, 2, 6, 1, 1, 1, {16'd0, 16'd0, 16'd1, 16'd4, 16'd1, 16'd3});

    model_reset();
    #12;
    model_compare();
    chk("rst_issue_index", 32'(issue_index), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 6; k++) sad_tab[k] = tbl[i].sads[k*16 +: 16];
      run_scn(tbl[i], 1'b0);
      check_table_entry(tbl[i]);
    end

    // err stays set in IDLE until the next accepted start.
    step(); step(); step();
    chk("err_sticky", 32'(err), 32'd1);

    // Abort in DRAIN with two results still in flight.
    sad_tab[0] = 16'd30; sad_tab[1] = 16'd10; sad_tab[2] = 16'd5; sad_tab[3] = 16'd1;
    begin_search(4, 3, -1);
    chk("err_cleared", 32'(err), 32'd0);
    while (cyc < 5) step();
    chk("drain_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_issue_valid", 32'(issue_valid), 32'd0);
    for (int k = 0; k < 4; k++) step();
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("stray_err", 32'(err), 32'd1);

    // Abort in the same cycle as the final result: abort wins, no done.
    sad_tab[0] = 16'd7;
    begin_search(1, 1, -1);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_final_busy", 32'(busy), 32'd0);
    step(); step();
    chk("abort_final_no_done", 32'(done_cnt), 32'd0);

    // Asynchronous reset in the middle of ISSUE.
    for (int k = 0; k < 8; k++) sad_tab[k] = SadW'(100 - k);
    begin_search(8, 2, -1);
    step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    model_compare();
    chk("rst_mid_issue_index", 32'(issue_index), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) sad_tab[k] = tbl[0].sads[k*16 +: 16];
    run_scn(tbl[0], 1'b0);
    check_table_entry(tbl[0]);

    // Randomized searches; best is recomputed here as a plain minimum scan.
    for (int r = 0; r < 20; r++) begin
      s = mk(int'($urandom_range(1, 12)), int'($urandom_range(0, 5)), 0, -1, 0, 0, 0, 0, 96'd0);
      ref_sad = '1;
      ref_idx = 0;
      for (int k = 0; k < s.n; k++) begin
        sad_tab[k] = SadW'($urandom_range(0, 15));
        if (sad_tab[k] < ref_sad) begin ref_sad = sad_tab[k]; ref_idx = k; end
      end
      run_scn(s, 1'b1);
      chk("rnd_best_idx", 32'(d_idx), 32'(ref_idx));
      chk("rnd_best_sad", 32'(d_sad), 32'(ref_sad));
      chk("rnd_err", 32'(d_err), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
